// File: rtl/alu_pkg.sv
// Shared decode-stage definitions: ALU select codes, opcodes, decoded bundle and skid FSM states.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [SEL_W-1:0] SEL_ADDI    = 6'h13;
  localparam logic [SEL_W-1:0] SEL_ANDI    = 6'h14;
  localparam logic [SEL_W-1:0] SEL_ORI     = 6'h15;
  localparam logic [SEL_W-1:0] SEL_XORI    = 6'h16;
  localparam logic [SEL_W-1:0] SEL_SLLI    = 6'h17;
  localparam logic [SEL_W-1:0] SEL_SRLI    = 6'h18;
  localparam logic [SEL_W-1:0] SEL_SRAI    = 6'h19;
  localparam logic [SEL_W-1:0] SEL_SLTI    = 6'h1A;
  localparam logic [SEL_W-1:0] SEL_SLTIU   = 6'h1B;
  localparam logic [SEL_W-1:0] SEL_ADD     = 6'h1C;
  localparam logic [SEL_W-1:0] SEL_SUB     = 6'h1D;
  localparam logic [SEL_W-1:0] SEL_AND     = 6'h1E;
  localparam logic [SEL_W-1:0] SEL_OR      = 6'h1F;
  localparam logic [SEL_W-1:0] SEL_XOR     = 6'h20;
  localparam logic [SEL_W-1:0] SEL_SLL     = 6'h21;
  localparam logic [SEL_W-1:0] SEL_SRL     = 6'h22;
  localparam logic [SEL_W-1:0] SEL_SRA     = 6'h23;
  localparam logic [SEL_W-1:0] SEL_SLT     = 6'h24;
  localparam logic [SEL_W-1:0] SEL_SLTU    = 6'h25;
  localparam logic [SEL_W-1:0] SEL_DEFAULT = 6'h3F;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [SEL_W-1:0] alu_select;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic             is_imm;
    logic             illegal;
  } dec_bundle_t;

  localparam dec_bundle_t BUNDLE_RST = '{
    alu_select: SEL_DEFAULT,
    rs1:        '0,
    rs2:        '0,
    rd:         '0,
    imm:        '0,
    is_imm:     1'b0,
    illegal:    1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_decoder.sv
// Pure combinational RV32I R/I ALU decode of one instruction word into a dec_bundle_t.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_bundle_t     dec_c
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [SEL_W-1:0] sel;
  logic             is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_shift = (funct3[1:0] == 2'b01);

  // Select code lookup; anything left at SEL_DEFAULT is an illegal encoding.
  always_comb begin
    sel = SEL_DEFAULT;
    case (opcode)
      OP_IMM: begin
        case (funct3)
          3'b000: sel = SEL_ADDI;
          3'b111: sel = SEL_ANDI;
          3'b110: sel = SEL_ORI;
          3'b100: sel = SEL_XORI;
          3'b010: sel = SEL_SLTI;
          3'b011: sel = SEL_SLTIU;
          3'b001: if (funct7 == F7_BASE) sel = SEL_SLLI;
          3'b101: begin
            if (funct7 == F7_BASE)     sel = SEL_SRLI;
            else if (funct7 == F7_ALT) sel = SEL_SRAI;
          end
          default: sel = SEL_DEFAULT;
        endcase
      end
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  sel = SEL_ADD;
            3'b111:  sel = SEL_AND;
            3'b110:  sel = SEL_OR;
            3'b100:  sel = SEL_XOR;
            3'b001:  sel = SEL_SLL;
            3'b101:  sel = SEL_SRL;
            3'b010:  sel = SEL_SLT;
            3'b011:  sel = SEL_SLTU;
            default: sel = SEL_DEFAULT;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      sel = SEL_SUB;
          else if (funct3 == 3'b101) sel = SEL_SRA;
        end
      end
      default: sel = SEL_DEFAULT;
    endcase
  end

  // Illegal words keep raw register fields so the downstream trap can report them.
  always_comb begin
    dec_c            = BUNDLE_RST;
    dec_c.rs1        = instr[19:15];
    dec_c.rs2        = instr[24:20];
    dec_c.rd         = instr[11:7];
    dec_c.alu_select = sel;
    dec_c.illegal    = (sel == SEL_DEFAULT);
    if ((sel != SEL_DEFAULT) && (opcode == OP_IMM)) begin
      dec_c.rs2    = '0;
      dec_c.is_imm = 1'b1;
      if (is_shift) dec_c.imm = XLEN'(instr[24:20]);
      else          dec_c.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with valid/ready handshake and a one-entry skid buffer.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] aluSelect,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic [XLEN-1:0]  imm,
  output logic             is_imm,
  output logic             illegal
);

  skid_state_e state_q, state_d;
  dec_bundle_t out_q, out_d;
  dec_bundle_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  dec_bundle_t dec_c;
  logic        accept;
  logic        consume;

  alu_decoder u_decoder (
    .instr (in_instr),
    .dec_c (dec_c)
  );

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_q       <= BUNDLE_RST;
      skid_q      <= BUNDLE_RST;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state: flush wins, empty slots are parked at reset values.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = BUNDLE_RST;
      skid_d  = BUNDLE_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = dec_c;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            out_d = dec_c;
          end else if (accept) begin
            skid_d  = dec_c;
            state_d = ST_SKID;
          end else if (consume) begin
            out_d   = BUNDLE_RST;
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (consume) begin
            out_d   = skid_q;
            skid_d  = BUNDLE_RST;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          out_d   = BUNDLE_RST;
          skid_d  = BUNDLE_RST;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign aluSelect = out_q.alu_select;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign is_imm    = out_q.is_imm;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage using directed cases and a scoreboard queue.
module tb_alu_decode_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  aluSelect;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        is_imm;
  logic        illegal;

  dec_bundle_t obs;
  dec_bundle_t sb[$];
  dec_bundle_t rst_b;
  int total = 0;
  int bad   = 0;

  alu_decode_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluSelect (aluSelect),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .is_imm    (is_imm),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs.alu_select = aluSelect;
    obs.rs1        = rs1;
    obs.rs2        = rs2;
    obs.rd         = rd;
    obs.imm        = imm;
    obs.is_imm     = is_imm;
    obs.illegal    = illegal;
  end

  function automatic dec_bundle_t mk(input logic [5:0] s, input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] d, input logic [31:0] i, input logic ii,
                                     input logic il);
    dec_bundle_t r;
    r.alu_select = s; r.rs1 = a; r.rs2 = b; r.rd = d; r.imm = i; r.is_imm = ii; r.illegal = il;
    return r;
  endfunction

  // Reference decoder: R-type codes from a funct3-indexed table, I-type from a case.
  function automatic dec_bundle_t ref_decode(input logic [31:0] w);
    dec_bundle_t r;
    logic [5:0]  rtab [8];
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [5:0]  s;
    rtab = '{6'h1C, 6'h21, 6'h24, 6'h25, 6'h20, 6'h22, 6'h1F, 6'h1E};
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12]; s = 6'h3F;
    if (op == 7'h13) begin
      case (f3)
        3'd0: s = 6'h13;
        3'd7: s = 6'h14;
        3'd6: s = 6'h15;
        3'd4: s = 6'h16;
        3'd2: s = 6'h1A;
        3'd3: s = 6'h1B;
        3'd1: s = (f7 == 7'h00) ? 6'h17 : 6'h3F;
        default: s = (f7 == 7'h00) ? 6'h18 : ((f7 == 7'h20) ? 6'h19 : 6'h3F);
      endcase
    end else if (op == 7'h33) begin
      if (f7 == 7'h00) s = rtab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) s = 6'h1D;
      else if (f7 == 7'h20 && f3 == 3'd5) s = 6'h23;
    end
    r = mk(s, w[19:15], w[24:20], w[11:7], 32'd0, 1'b0, (s == 6'h3F));
    if (s != 6'h3F && op == 7'h13) begin
      r.rs2    = 5'd0;
      r.is_imm = 1'b1;
      r.imm    = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 3);
    if (k == 0 || k == 2) w[6:0] = 7'h13;
    else if (k == 1)      w[6:0] = 7'h33;
    k = $urandom_range(0, 2);
    if (k == 0)      w[31:25] = 7'h00;
    else if (k == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== rst_b || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: got %h v=%b r=%b want %h v=0 r=1", obs, out_valid, in_ready, rst_b);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== rst_b || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got %h v=%b r=%b want %h v=0 r=1", obs, out_valid, in_ready, rst_b);
    end
  endtask

  task automatic test_directed();
    logic [31:0] dw [5];
    dec_bundle_t de [5];
    dw[0] = 32'hFFF10093; de[0] = mk(6'h13, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
    dw[1] = 32'h402081B3; de[1] = mk(6'h1D, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0);
    dw[2] = 32'h40435293; de[2] = mk(6'h19, 5'd6, 5'd0, 5'd5, 32'd4, 1'b1, 1'b0);
    dw[3] = 32'hC0435293; de[3] = mk(6'h3F, 5'd6, 5'd4, 5'd5, 32'd0, 1'b0, 1'b1);
    dw[4] = 32'h00012083; de[4] = mk(6'h3F, 5'd2, 5'd0, 5'd1, 32'd0, 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = dw[i];
      @(posedge clk); #1;
      total++;
      if (obs !== de[i] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d: got %h v=%b r=%b want %h v=1 r=1", i, obs, out_valid, in_ready, de[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== rst_b || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_drain: got %h v=%b want %h v=0", obs, out_valid, rst_b);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] bw [3];
    int idx = 0;
    int got = 0;
    bw[0] = 32'hFFF10093; bw[1] = 32'h402081B3; bw[2] = 32'h40435293;
    sb.delete();
    for (int cyc = 0; cyc < 20 && (idx < 3 || sb.size() > 0); cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 3);
      in_instr  = (idx < 3) ? bw[idx] : 32'd0;
      @(negedge clk);
      if (cyc == 2) begin
        total++;
        if (in_ready !== 1'b0 || idx != 2) begin
          bad++;
          $display("FAIL bp_in_ready: got r=%b accepted=%0d want r=0 accepted=2", in_ready, idx);
        end
      end
      if (out_valid) begin
        total++;
        if (sb.size() == 0 || obs !== sb[0]) begin
          bad++;
          $display("FAIL bp_bundle: got %h want %h (queued=%0d)", obs, (sb.size() > 0) ? sb[0] : rst_b, sb.size());
        end
        if (out_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_decode(in_instr));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (got != 3 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got %0d drained, %0d left want 3 drained, 0 left", got, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int con = 0;
    sb.delete();
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 60) begin
        in_valid = 1'b1; out_ready = 1'b1;
      end else if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      in_instr = gen_instr();
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (sb.size() == 0 || obs !== sb[0]) begin
          bad++;
          $display("FAIL stream_bundle cyc=%0d: got %h want %h", cyc, obs, (sb.size() > 0) ? sb[0] : rst_b);
        end
        if (out_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          con++;
        end
      end else begin
        total++;
        if (obs !== rst_b) begin
          bad++;
          $display("FAIL stream_idle cyc=%0d: got %h want %h", cyc, obs, rst_b);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_decode(in_instr));
        acc++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (acc != con || sb.size() != 0 || acc < 100) begin
      bad++;
      $display("FAIL stream_count: got accepted=%0d consumed=%0d left=%0d want equal, 0 left", acc, con, sb.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093; @(posedge clk); #1;
    in_instr = 32'h402081B3; @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_setup: got r=%b want r=0", in_ready);
    end
    flush = 1'b1; in_instr = 32'h40435293;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    total++;
    if (obs !== rst_b || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: got %h v=%b r=%b want %h v=0 r=1", obs, out_valid, in_ready, rst_b);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || obs !== rst_b) begin
        bad++;
        $display("FAIL flush_stale_%0d: got %h v=%b want %h v=0", i, obs, out_valid, rst_b);
      end
    end
    in_valid = 1'b1; in_instr = 32'h0062A3B3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (obs !== ref_decode(32'h0062A3B3) || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_resume: got %h v=%b want %h v=1", obs, out_valid, ref_decode(32'h0062A3B3));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h40435293; @(posedge clk); #1;
    in_instr = 32'h00C5F513; @(posedge clk); #1;
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    total++;
    if (obs !== rst_b || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got %h v=%b r=%b want %h v=0 r=1", obs, out_valid, in_ready, rst_b);
    end
    #1 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h00C5F513;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (obs !== ref_decode(32'h00C5F513) || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_decode: got %h v=%b want %h v=1", obs, out_valid, ref_decode(32'h00C5F513));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_b = mk(6'h3F, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
